// File: rtl/fract_pixel_scheduler.sv
// Frame scheduler for a bank of Mandelbrot iteration cores: walks the raster,
// hands each pixel's c to the lowest-index idle core, collects finished pixels
// round-robin and writes them to the single framebuffer port.
module fract_pixel_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120,
  parameter int FRAC      = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_frame,
  input  logic [31:0]          centerx,
  input  logic [31:0]          centery,
  output logic [NUM_CORES-1:0] core_start,
  output logic [31:0]          core_cr,
  output logic [31:0]          core_ci,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_pixel,
  output logic [NUM_CORES-1:0] core_ack,
  output logic                 fb_we,
  output logic [18:0]          fb_addr,
  output logic                 fb_data,
  output logic                 frame_busy,
  output logic                 frame_done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic signed [31:0]    cx, cy;
  logic [15:0]           x, y;
  logic [18:0]           pix_addr;
  logic [NUM_CORES-1:0]  busy;
  logic [18:0]           tag [NUM_CORES];
  logic [IDX_W-1:0]      rr;

  logic                  do_disp, do_grant;
  logic [IDX_W-1:0]      disp_idx, grant_idx;
  logic [NUM_CORES-1:0]  req;
  logic                  last_pixel;
  logic signed [31:0]    x_s, y_s;

  // Integer cartesian coordinate to fixed point; overflow wraps silently.
  function automatic logic signed [31:0] to_fixed(input logic signed [31:0] v);
    return v <<< FRAC;
  endfunction

  // Fold a rotated core index back into 0..NUM_CORES-1.
  function automatic int wrap_idx(input int v);
    return (v >= NUM_CORES) ? v - NUM_CORES : v;
  endfunction

  assign req        = core_done & busy;
  assign last_pixel = (x == 16'(SCR_W - 1)) && (y == 16'(SCR_H - 1));
  assign x_s        = signed'({16'd0, x});
  assign y_s        = signed'({16'd0, y});

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Dispatch/grant selection, datapath outputs and next-state decode.
  always_comb begin
    state_nxt  = state;
    core_start = '0;
    core_cr    = '0;
    core_ci    = '0;
    core_ack   = '0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = 1'b0;
    frame_busy = 1'b0;
    frame_done = 1'b0;
    do_disp    = 1'b0;
    disp_idx   = '0;
    do_grant   = 1'b0;
    grant_idx  = '0;

    // Lowest-index idle core wins the dispatch slot; an acked core is still
    // marked busy this cycle, so it cannot be restarted until the next one.
    if (state == S_DISPATCH) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (!busy[i]) begin
          do_disp  = 1'b1;
          disp_idx = IDX_W'(i);
        end
      end
    end

    // Round-robin search over finished cores starting at rr.
    if (state == S_DISPATCH || state == S_DRAIN) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (!do_grant && req[wrap_idx(int'(rr) + j)]) begin
          do_grant  = 1'b1;
          grant_idx = IDX_W'(wrap_idx(int'(rr) + j));
        end
      end
    end

    if (do_disp) begin
      core_start[disp_idx] = 1'b1;
      core_cr              = to_fixed(x_s - cx);
      core_ci              = to_fixed(cy - y_s);
    end

    if (do_grant) begin
      core_ack[grant_idx] = 1'b1;
      fb_we               = 1'b1;
      fb_addr             = tag[grant_idx];
      fb_data             = core_pixel[grant_idx];
    end

    case (state)
      S_IDLE:     if (start_frame) state_nxt = S_DISPATCH;
      S_DISPATCH: begin
        frame_busy = 1'b1;
        if (do_disp && last_pixel) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        frame_busy = 1'b1;
        if (busy == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster position, pan latch, per-core busy/tag bookkeeping and rr pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      cx       <= '0;
      cy       <= '0;
      x        <= '0;
      y        <= '0;
      pix_addr <= '0;
      busy     <= '0;
      rr       <= '0;
      for (int i = 0; i < NUM_CORES; i++) tag[i] <= '0;
    end else begin
      if (state == S_IDLE && start_frame) begin
        cx       <= signed'(centerx);
        cy       <= signed'(centery);
        x        <= '0;
        y        <= '0;
        pix_addr <= '0;
      end
      if (do_disp) begin
        tag[disp_idx] <= pix_addr;
        pix_addr      <= pix_addr + 19'd1;
        if (x == 16'(SCR_W - 1)) begin
          x <= '0;
          y <= y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
      end
      busy <= (busy & ~core_ack) | core_start;
      if (do_grant) begin
        rr <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fract_pixel_scheduler.sv
// Directed bench for fract_pixel_scheduler: a 1-core 4x2 instance and a
// 4-core 160x120 instance, with behavioural core models driven from tasks.
module tb_fract_pixel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // 1-core, 4x2 instance
  logic        a_sf;
  logic [31:0] a_cx, a_cy, a_cr, a_ci;
  logic [0:0]  a_cs, a_done, a_pix, a_ack;
  logic        a_we, a_data, a_busy, a_fd;
  logic [18:0] a_addr;

  // 4-core, 160x120 instance
  logic        b_sf;
  logic [31:0] b_cx, b_cy, b_cr, b_ci;
  logic [3:0]  b_cs, b_done, b_pix, b_ack;
  logic        b_we, b_data, b_busy, b_fd;
  logic [18:0] b_addr;

  bit seen [19200];

  fract_pixel_scheduler #(.NUM_CORES(1), .SCR_W(4), .SCR_H(2), .FRAC(18)) dut_a (
    .clk(clk), .reset(reset), .start_frame(a_sf), .centerx(a_cx), .centery(a_cy),
    .core_start(a_cs), .core_cr(a_cr), .core_ci(a_ci), .core_done(a_done),
    .core_pixel(a_pix), .core_ack(a_ack), .fb_we(a_we), .fb_addr(a_addr),
    .fb_data(a_data), .frame_busy(a_busy), .frame_done(a_fd)
  );

  fract_pixel_scheduler #(.NUM_CORES(4), .SCR_W(160), .SCR_H(120), .FRAC(18)) dut_b (
    .clk(clk), .reset(reset), .start_frame(b_sf), .centerx(b_cx), .centery(b_cy),
    .core_start(b_cs), .core_cr(b_cr), .core_ci(b_ci), .core_done(b_done),
    .core_pixel(b_pix), .core_ack(b_ack), .fb_we(b_we), .fb_addr(b_addr),
    .fb_data(b_data), .frame_busy(b_busy), .frame_done(b_fd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset  = 1'b0;
    a_done = 1'b1;
    b_done = 4'hF;
    b_pix  = 4'hF;
    @(negedge clk);
    checks++;
    if ({a_cs, a_ack, a_we, a_addr, a_data, a_busy, a_fd, a_cr, a_ci} !== '0) begin
      errors++;
      $display("FAIL rst_a_outputs: got cs=%b ack=%b we=%b busy=%b fd=%b, expected all 0", a_cs, a_ack, a_we, a_busy, a_fd);
    end
    checks++;
    if ({b_cs, b_ack, b_we, b_busy, b_fd} !== '0) begin
      errors++;
      $display("FAIL rst_b_ctrl: got cs=%b ack=%b we=%b busy=%b fd=%b, expected all 0", b_cs, b_ack, b_we, b_busy, b_fd);
    end
    checks++;
    if ({b_addr, b_data, b_cr, b_ci} !== '0) begin
      errors++;
      $display("FAIL rst_b_data: got addr=%0d data=%b cr=%h ci=%h, expected all 0", b_addr, b_data, b_cr, b_ci);
    end
    tick();
    a_done = 1'b0;
    b_done = 4'h0;
    b_pix  = 4'h0;
  endtask

  task automatic test_single_core();
    int nd = 0, nw = 0, nfd = 0, cnt = 0, ex, ey;
    logic [31:0] ecr, eci;
    logic st, ak, pv;
    pv   = 1'b0;
    a_cx = 32'd2;
    a_cy = 32'd1;
    a_sf = 1'b1;
    tick();
    a_sf = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      st = a_cs[0];
      ak = a_ack[0];
      if (cyc == 0) begin
        checks++;
        if (a_cs !== 1'b1 || a_busy !== 1'b1) begin
          errors++;
          $display("FAIL single_latency: got cs=%b busy=%b, expected 1 1", a_cs, a_busy);
        end
        checks++;
        if (a_cr !== 32'hFFF8_0000 || a_ci !== 32'h0004_0000) begin
          errors++;
          $display("FAIL single_first_c: got cr=%h ci=%h, expected fff80000 00040000", a_cr, a_ci);
        end
      end
      if (st) begin
        ex  = nd % 4 - 2;
        ey  = 1 - nd / 4;
        ecr = ex << 18;
        eci = ey << 18;
        checks++;
        if (a_cr !== ecr || a_ci !== eci) begin
          errors++;
          $display("FAIL single_dispatch: pixel %0d got cr=%h ci=%h, expected cr=%h ci=%h", nd, a_cr, a_ci, ecr, eci);
        end
        nd++;
      end
      if (a_we) begin
        checks++;
        if (a_addr !== 19'(nw) || a_data !== pv || nfd > 0) begin
          errors++;
          $display("FAIL single_write: got addr=%0d data=%b, expected addr=%0d data=%b", a_addr, a_data, nw, pv);
        end
        nw++;
      end
      if (a_fd) nfd++;
      tick();
      if (ak) a_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          a_done = 1'b1;
          a_pix  = 1'($urandom);
          pv     = a_pix[0];
        end
      end
      if (st) cnt = 3;
    end
    checks++;
    if (nd != 8 || nw != 8) begin
      errors++;
      $display("FAIL single_counts: got dispatches=%0d writes=%0d, expected 8 8", nd, nw);
    end
    checks++;
    if (nfd != 1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_frame_done: got pulses=%0d busy=%b, expected 1 0", nfd, a_busy);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_cs [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [3:0] ecs;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_cx  = 32'd80;
    b_cy  = 32'd60;
    b_sf  = 1'b1;
    tick();
    b_sf  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (b_cs !== exp_cs[k]) begin
        errors++;
        $display("FAIL arb_dispatch_%0d: got cs=%b, expected %b", k, b_cs, exp_cs[k]);
      end
      tick();
    end
    b_done = 4'hF;
    b_pix  = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ecs = (k == 0) ? 4'b0000 : 4'(1 << (k - 1));
      checks++;
      if (b_ack !== 4'(1 << k) || b_we !== 1'b1 || b_addr !== 19'(k) || b_data !== b_pix[k] || b_cs !== ecs) begin
        errors++;
        $display("FAIL arb_grant_%0d: got ack=%b we=%b addr=%0d data=%b cs=%b, expected ack=%b we=1 addr=%0d data=%b cs=%b",
                 k, b_ack, b_we, b_addr, b_data, b_cs, 4'(1 << k), k, b_pix[k], ecs);
      end
      tick();
      b_done[k] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b1000 || b_ack !== 4'b0000) begin
      errors++;
      $display("FAIL arb_redispatch: got cs=%b ack=%b, expected 1000 0000", b_cs, b_ack);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0000) begin
      errors++;
      $display("FAIL arb_all_busy: got cs=%b, expected 0000", b_cs);
    end
    tick();
  endtask

  task automatic test_rr_rotation();
    int gseq [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int aseq [8] = '{7, 4, 5, 8, 9, 10, 11, 12};
    b_done = 4'b0100;
    @(negedge clk);
    checks++;
    if (b_ack !== 4'b0100 || b_addr !== 19'd6) begin
      errors++;
      $display("FAIL rr_setup: got ack=%b addr=%0d, expected 0100 6", b_ack, b_addr);
    end
    tick();
    b_done = 4'b0000;
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0100) begin
      errors++;
      $display("FAIL rr_setup_restart: got cs=%b, expected 0100", b_cs);
    end
    tick();
    b_done = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (b_ack !== 4'(1 << gseq[i]) || b_addr !== 19'(aseq[i])) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ack=%b addr=%0d, expected ack=%b addr=%0d", i, b_ack, b_addr, 4'(1 << gseq[i]), aseq[i]);
      end
      tick();
      if (i == 7) b_done = 4'h0;
    end
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0100 || b_ack !== 4'b0000) begin
      errors++;
      $display("FAIL rr_tail: got cs=%b ack=%b, expected 0100 0000", b_cs, b_ack);
    end
    tick();
  endtask

  task automatic test_start_ignored_dispatch();
    b_sf   = 1'b1;
    b_cx   = 32'd50;
    b_cy   = 32'd7;
    b_done = 4'b0001;
    @(negedge clk);
    checks++;
    if (b_ack !== 4'b0001 || b_addr !== 19'd14 || b_busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_grant: got ack=%b addr=%0d busy=%b, expected 0001 14 1", b_ack, b_addr, b_busy);
    end
    tick();
    b_sf   = 1'b0;
    b_done = 4'b0000;
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0001 || b_cr !== 32'hFF04_0000 || b_ci !== 32'h00F0_0000) begin
      errors++;
      $display("FAIL ign_pan: got cs=%b cr=%h ci=%h, expected 0001 ff040000 00f00000", b_cs, b_cr, b_ci);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b_cx  = 32'd80;
    b_cy  = 32'd60;
    b_sf  = 1'b1;
    tick();
    b_sf  = 1'b0;
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first: got cs=%b, expected 0001", b_cs);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b_cs !== 4'b0010) begin
      errors++;
      $display("FAIL mid_second: got cs=%b, expected 0010", b_cs);
    end
    tick();
    reset  = 1'b1;
    b_done = 4'h0;
    tick();
    reset  = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_cs, b_ack, b_we, b_busy, b_fd} !== '0 || {b_addr, b_data, b_cr, b_ci} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got cs=%b ack=%b we=%b busy=%b fd=%b addr=%0d cr=%h, expected all 0",
               b_cs, b_ack, b_we, b_busy, b_fd, b_addr, b_cr);
    end
    tick();
  endtask

  task automatic test_full_frame();
    int nd = 0, nw = 0, nfd = 0, post = 0, poked = 0, nseen = 0, g, ex, ey;
    int cnt [4] = '{0, 0, 0, 0};
    logic [31:0] ecr, eci;
    logic [3:0] st, ak, pv;
    pv = 4'h0;
    for (int i = 0; i < 19200; i++) seen[i] = 1'b0;
    b_cx = 32'd80;
    b_cy = 32'd60;
    b_sf = 1'b1;
    tick();
    b_sf = 1'b0;
    for (int cyc = 0; cyc < 60000 && post < 5; cyc++) begin
      @(negedge clk);
      st = b_cs;
      ak = b_ack;
      if (st != 4'h0) begin
        ex  = nd % 160 - 80;
        ey  = 60 - nd / 160;
        ecr = ex << 18;
        eci = ey << 18;
        checks++;
        if ($countones(st) != 1 || b_cr !== ecr || b_ci !== eci) begin
          errors++;
          $display("FAIL full_dispatch: pixel %0d got cs=%b cr=%h ci=%h, expected cr=%h ci=%h", nd, st, b_cr, b_ci, ecr, eci);
        end
        nd++;
      end
      if (b_we) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (ak[i]) g = i;
        checks++;
        if ($countones(ak) != 1 || int'(b_addr) >= 19200 || nfd > 0 || b_data !== pv[g]) begin
          errors++;
          $display("FAIL full_write: got ack=%b addr=%0d data=%b after_done=%0d, expected one-hot ack, addr<19200, data=%b",
                   ak, b_addr, b_data, nfd, pv[g]);
        end else if (seen[b_addr]) begin
          errors++;
          $display("FAIL full_duplicate: got second write to addr %0d, expected exactly one", b_addr);
        end else begin
          seen[b_addr] = 1'b1;
        end
        nw++;
      end
      if (b_fd) begin
        nfd++;
        checks++;
        if (b_busy !== 1'b0) begin
          errors++;
          $display("FAIL full_busy_drop: got busy=%b with frame_done, expected 0", b_busy);
        end
      end
      if (nfd > 0) post++;
      tick();
      b_sf = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (ak[i]) b_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            b_done[i] = 1'b1;
            b_pix[i]  = 1'($urandom);
            pv[i]     = b_pix[i];
          end
        end
        if (st[i]) cnt[i] = int'($urandom_range(1, 7));
      end
      if (nd == 19200 && poked == 0) begin
        b_sf  = 1'b1;
        b_cx  = 32'd5;
        b_cy  = 32'd5;
        poked = 1;
      end
    end
    for (int i = 0; i < 19200; i++) if (seen[i]) nseen++;
    checks++;
    if (nd != 19200 || nw != 19200 || nseen != 19200) begin
      errors++;
      $display("FAIL full_counts: got dispatches=%0d writes=%0d distinct=%0d, expected 19200 each", nd, nw, nseen);
    end
    checks++;
    if (nfd != 1 || poked != 1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_frame_done: got pulses=%0d drain_start=%0d busy=%b, expected 1 1 0", nfd, poked, b_busy);
    end
  endtask

  initial begin
    reset  = 1'b1;
    a_sf   = 1'b0;  a_cx = '0;  a_cy = '0;  a_done = '0;  a_pix = '0;
    b_sf   = 1'b0;  b_cx = '0;  b_cy = '0;  b_done = '0;  b_pix = '0;
    test_reset();
    test_single_core();
    test_arbitration();
    test_rr_rotation();
    test_start_ignored_dispatch();
    test_reset_midframe();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
